// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// cycle, followed by a sign/override fix-up cycle and a registered result cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [W-1:0]    r_hi, r_lo, r_b, r_rs1, r_res;
    logic            r_neg_res, r_neg_rem, r_div0, r_ovf, r_done;

    // Operand decode at the accepting edge
    logic            w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [W-1:0]    w_a_mag, w_b_mag;

    assign w_accept   = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_a_signed = op_i[2] ? !op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    assign w_b_signed = op_i[2] ? !op_i[0] : (op_i[1:0] == 2'b01);
    assign w_a_neg    = w_a_signed && rs1_data_i[W-1];
    assign w_b_neg    = w_b_signed && rs2_data_i[W-1];
    assign w_a_mag    = w_a_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
    assign w_b_mag    = w_b_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;

    // Iteration step: multiply adds the multiplicand into the high half and
    // shifts right; divide shifts the remainder left and trial-subtracts.
    logic [W:0]      w_sum, w_rsh;
    logic [W-1:0]    w_diff;
    logic            w_ge;

    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    assign w_rsh  = {r_hi, r_lo[W-1]};
    assign w_ge   = (w_rsh >= {1'b0, r_b});
    // Remainder after a successful subtract is below the divisor, so W bits suffice
    assign w_diff = w_rsh[W-1:0] - r_b;

    // Fix-up: sign correction and the zero-divisor / overflow overrides
    logic [2*W-1:0]  w_prod, w_prod_s;
    logic [W-1:0]    w_quo_s, w_rem_s, w_fix;

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_res ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_s  = r_neg_res ? (~r_lo + 1'b1) : r_lo;
    assign w_rem_s  = r_neg_rem ? (~r_hi + 1'b1) : r_hi;

    // Result selection for the fix-up cycle
    always_comb begin
        w_fix = '0;
        if (!r_op[2]) begin
            w_fix = (r_op[1:0] == 2'b00) ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W];
        end else if (!r_op[1]) begin
            if (r_div0)     w_fix = '1;
            else if (r_ovf) w_fix = MOST_NEG;
            else            w_fix = w_quo_s;
        end else begin
            if (r_div0)     w_fix = r_rs1;
            else if (r_ovf) w_fix = '0;
            else            w_fix = w_rem_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; flush returns to idle from any active state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_CALC;
            S_CALC: if (flush_i) w_next = S_IDLE;
                    else if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath, fix-up and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_rs1     <= '0;
            r_res     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            result_o  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt     <= CW'(W);
                    r_op      <= op_i;
                    r_hi      <= '0;
                    // Divide: lo holds the dividend, b the divisor.
                    // Multiply: lo holds the multiplier, b the multiplicand.
                    r_lo      <= op_i[2] ? w_a_mag : w_b_mag;
                    r_b       <= op_i[2] ? w_b_mag : w_a_mag;
                    r_rs1     <= rs1_data_i;
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    r_div0    <= op_i[2] && (rs2_data_i == '0);
                    r_ovf     <= op_i[2] && !op_i[0] &&
                                 (rs1_data_i == MOST_NEG) && (rs2_data_i == '1);
                end
                S_CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (!r_op[2]) begin
                        r_hi <= w_sum[W:1];
                        r_lo <= {w_sum[0], r_lo[W-1:1]};
                    end else begin
                        r_hi <= w_ge ? w_diff : w_rsh[W-1:0];
                        r_lo <= {r_lo[W-2:0], w_ge};
                    end
                end
                S_FIX:  r_res <= w_fix;
                S_DONE: if (!flush_i) begin
                    result_o <= r_res;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (r_state != S_IDLE);
    assign done_o = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_WIDTH = 32).
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int LAT = 34;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    // Reference model straight from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            3'd0: begin up = ua * ub; r = up[31:0]; end
            3'd1: begin sp = sa * sb; r = sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4: if (b == 0) r = 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                  else r = $signed(a) / $signed(b);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                  else r = $signed(a) % $signed(b);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op (caller sits #1 after a rising edge with the unit idle),
    // scramble the inputs after acceptance, and wait a bounded time for done.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit busy_ok);
        op_i = op; rs1_data_i = a; rs2_data_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        op_i = 3'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom;
        busy_ok = (busy_o === 1'b1);
        lat = -1;
        res = 'x;
        for (int j = 1; j <= 60; j++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                lat = j;
                res = result_o;
                if (busy_o !== 1'b0) busy_ok = 1'b0;
                break;
            end else if (busy_o !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy_o, done_o, result_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h, want 0/0/0", busy_o, done_o, result_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_latency();
        logic [31:0] res; int lat; bit bok;
        do_op(3'd0, 32'd100, 32'd200, res, lat, bok);
        n_checks++;
        if (res !== 32'd20000 || lat != LAT || !bok) begin
            n_fail++;
            $display("FAIL mul_latency: result=%0d lat=%0d busy_ok=%0d, want 20000/%0d/1", res, lat, bok, LAT);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done_o !== 1'b0 || result_o !== 32'd20000) begin
            n_fail++;
            $display("FAIL done_pulse_width: done=%b result=%0d, want 0/20000", done_o, result_o);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops[13] = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
        logic [31:0] as[13]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'd300, 32'd300, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                 32'hFFFF_FFF9};
        logic [31:0] bs[13]  = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ex[13]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'd42, 32'd6, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                 32'hFFFF_FFFF};
        logic [31:0] res; int lat; bit bok;
        for (int i = 0; i < 13; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat, bok);
            n_checks++;
            if (res !== ex[i] || lat != LAT || !bok) begin
                n_fail++;
                $display("FAIL directed[%0d] op=%0d a=%h b=%h: result=%h lat=%0d busy_ok=%0d, want %h/%0d/1",
                         i, ops[i], as[i], bs[i], res, lat, bok, ex[i], LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pool[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        logic [31:0] a, b, res; logic [2:0] op; int lat; bit bok;
        for (int i = 0; i < 48; i++) begin
            op = 3'(i % 8);
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(1, 28);
            do_op(op, a, b, res, lat, bok);
            n_checks++;
            if (res !== model(op, a, b) || lat != LAT || !bok) begin
                n_fail++;
                $display("FAIL random op=%0d a=%h b=%h: result=%h lat=%0d busy_ok=%0d, want %h/%0d/1",
                         op, a, b, res, lat, bok, model(op, a, b), LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2; int l1, l2; bit b1, b2;
        do_op(3'd1, 32'h1234_5678, 32'h8765_4321, r1, l1, b1);
        do_op(3'd6, 32'h8765_4321, 32'd1000, r2, l2, b2);
        n_checks++;
        if (r1 !== model(3'd1, 32'h1234_5678, 32'h8765_4321) || l1 != LAT ||
            r2 !== model(3'd6, 32'h8765_4321, 32'd1000) || l2 != LAT || !b1 || !b2) begin
            n_fail++;
            $display("FAIL back_to_back: r1=%h l1=%0d r2=%h l2=%0d, want %h/%0d %h/%0d",
                     r1, l1, r2, l2, model(3'd1, 32'h1234_5678, 32'h8765_4321), LAT,
                     model(3'd6, 32'h8765_4321, 32'd1000), LAT);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res, old; int lat; bit bok, saw_done;
        old = result_o;
        op_i = 3'd0; rs1_data_i = 32'd7; rs2_data_i = 32'd9; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: busy=%b, want 0", busy_o);
        end
        saw_done = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done || result_o !== old) begin
            n_fail++;
            $display("FAIL flush_no_done: saw_done=%0d result=%h, want 0/%h", saw_done, result_o, old);
        end
        // A flush in idle must block a simultaneous start
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_start: busy=%b, want 0", busy_o);
        end
        do_op(3'd0, 32'd3, 32'd4, res, lat, bok);
        n_checks++;
        if (res !== 32'd12 || lat != LAT || !bok) begin
            n_fail++;
            $display("FAIL restart_after_flush: result=%0d lat=%0d, want 12/%0d", res, lat, LAT);
        end
    endtask

    task automatic test_busy_ignore();
        int  lat, n_done;
        logic [31:0] res;
        op_i = 3'd5; rs1_data_i = 32'd300; rs2_data_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        op_i = 3'd0; rs1_data_i = 32'd11; rs2_data_i = 32'd13; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 6; n_done = 0; res = '0;
        for (int j = 0; j < 80; j++) begin
            @(posedge clk); #1;
            lat++;
            if (done_o === 1'b1) begin
                if (n_done == 0) res = result_o;
                n_done++;
            end
        end
        n_checks++;
        if (n_done != 1 || res !== 32'd42) begin
            n_fail++;
            $display("FAIL busy_ignore: done_count=%0d result=%0d, want 1/42", n_done, res);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        op_i = 3'd4; rs1_data_i = 32'hFFFF_FF00; rs2_data_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({busy_o, done_o, result_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h, want 0/0/0", busy_o, done_o, result_o);
        end
        saw_done = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: saw_done=%0d busy=%b, want 0/0", saw_done, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
